// File: rtl/alu_pkg.sv
// alu_pkg: RV32I OP/OP-IMM encodings and the ALU micro-op shared by the issue stage and alu32_top
package alu_pkg;
   localparam logic [6:0] OPCODE_R = 7'b0110011;
   localparam logic [6:0] OPCODE_I = 7'b0010011;
   localparam logic [6:0] F7_BASE  = 7'b0000000;
   localparam logic [6:0] F7_ALT   = 7'b0100000;
   localparam logic [2:0] F3_ADD   = 3'b000;
   localparam logic [2:0] F3_SLL   = 3'b001;
   localparam logic [2:0] F3_SR    = 3'b101;
   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [6:0]  opcode;
      logic [2:0]  func3;
      logic [6:0]  func7;
      logic [31:0] imm;
      logic [4:0]  rd;
   } alu_uop_t;
endpackage

// File: rtl/alu_skid_buffer.sv
// alu_skid_buffer: 2-entry valid/ready skid (main output register plus one overflow entry)
module alu_skid_buffer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
);
   logic             skid_valid;
   logic [WIDTH-1:0] skid_data;
   logic             push;
   logic             load;
   assign in_ready = !skid_valid;
   assign push     = in_valid && in_ready;
   assign load     = !out_valid || out_ready;
   // in_ready is low whenever the skid holds data, so push and skid_valid never coincide
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         skid_valid <= 1'b0;
         skid_data  <= '0;
      end else if (flush) begin
         out_valid  <= 1'b0;
         skid_valid <= 1'b0;
      end else if (load) begin
         out_valid  <= skid_valid || push;
         out_data   <= skid_valid ? skid_data : push ? in_data : out_data;
         skid_valid <= 1'b0;
      end else if (push) begin
         skid_valid <= 1'b1;
         skid_data  <= in_data;
      end
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes RV32I OP/OP-IMM into an ALU micro-op, drops and counts illegal encodings
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [XLEN-1:0]  in_rs1_data,
   input  logic [XLEN-1:0]  in_rs2_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_A,
   output logic [XLEN-1:0]  out_B,
   output logic [6:0]       out_opcode,
   output logic [2:0]       out_func3,
   output logic [6:0]       out_func7,
   output logic [XLEN-1:0]  out_imm,
   output logic [4:0]       out_rd,
   output logic             illegal_pulse,
   output logic [CNT_W-1:0] illegal_count
);
   logic [6:0] opcode;
   logic [2:0] func3;
   logic [6:0] func7;
   logic       is_r;
   logic       is_i;
   logic       is_shift;
   logic       legal;
   logic       drop;
   logic       unused_rs1;
   alu_uop_t   uop;
   alu_uop_t   head;
   assign opcode     = in_instr[6:0];
   assign func3      = in_instr[14:12];
   assign func7      = in_instr[31:25];
   assign unused_rs1 = ^in_instr[19:15];
   assign is_r       = opcode == OPCODE_R;
   assign is_i       = opcode == OPCODE_I;
   assign is_shift   = is_i && (func3 == F3_SLL || func3 == F3_SR);
   always_comb begin
      legal = is_r ? (func7 == F7_BASE || (func7 == F7_ALT && (func3 == F3_ADD || func3 == F3_SR)))
            : !is_i ? 1'b0
            : func3 == F3_SLL ? func7 == F7_BASE
            : func3 == F3_SR ? (func7 == F7_BASE || func7 == F7_ALT)
            : 1'b1;
      uop.a      = in_rs1_data;
      uop.imm    = is_r ? 32'd0 : is_shift ? {27'd0, in_instr[24:20]} : {{20{in_instr[31]}}, in_instr[31:20]};
      uop.b      = is_r ? in_rs2_data : uop.imm;
      uop.opcode = opcode;
      uop.func3  = func3;
      uop.func7  = (is_r || is_shift) ? func7 : 7'd0;
      uop.rd     = in_instr[11:7];
   end
   alu_skid_buffer #(.WIDTH($bits(alu_uop_t))) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid && legal),
      .in_ready  (in_ready),
      .in_data   (uop),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (head)
   );
   assign out_A      = head.a;
   assign out_B      = head.b;
   assign out_opcode = head.opcode;
   assign out_func3  = head.func3;
   assign out_func7  = head.func7;
   assign out_imm    = head.imm;
   assign out_rd     = head.rd;
   // illegal ops still complete the input handshake; a flush in the same cycle cancels the report
   assign drop = in_valid && in_ready && !legal && !flush;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         illegal_pulse <= 1'b0;
         illegal_count <= '0;
      end else begin
         illegal_pulse <= drop;
         if (drop && illegal_count != '1) illegal_count <= illegal_count + 1'b1;
      end
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed and random stimulus against a queue-based reference of the issue stage
module tb_alu_issue_stage;
   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] imm;
      logic [4:0]  rd;
   } ref_uop_t;

   logic        clk = 0;
   logic        rst_n = 0;
   logic        flush = 0;
   logic        in_valid = 0;
   logic        in_ready;
   logic [31:0] in_instr = 0;
   logic [31:0] in_rs1_data = 0;
   logic [31:0] in_rs2_data = 0;
   logic        out_valid;
   logic        out_ready = 0;
   logic [31:0] out_A, out_B, out_imm;
   logic [6:0]  out_opcode, out_func7;
   logic [2:0]  out_func3;
   logic [4:0]  out_rd;
   logic        illegal_pulse;
   logic [7:0]  illegal_count;
   logic        d2_in_ready, d2_out_valid, d2_pulse;
   logic [31:0] d2_a, d2_b, d2_imm;
   logic [6:0]  d2_op, d2_f7;
   logic [2:0]  d2_f3;
   logic [4:0]  d2_rd;
   logic [1:0]  d2_count;

   int checks = 0;
   int errors = 0;
   ref_uop_t q[$];
   bit  m_pulse = 0;
   int  m_count = 0;

   always #5 clk = ~clk;

   alu_issue_stage #(.XLEN(32), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_A(out_A), .out_B(out_B),
      .out_opcode(out_opcode), .out_func3(out_func3), .out_func7(out_func7), .out_imm(out_imm),
      .out_rd(out_rd), .illegal_pulse(illegal_pulse), .illegal_count(illegal_count));

   alu_issue_stage #(.XLEN(32), .CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(d2_in_ready),
      .in_instr(in_instr), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
      .out_valid(d2_out_valid), .out_ready(out_ready), .out_A(d2_a), .out_B(d2_b),
      .out_opcode(d2_op), .out_func3(d2_f3), .out_func7(d2_f7), .out_imm(d2_imm),
      .out_rd(d2_rd), .illegal_pulse(d2_pulse), .illegal_count(d2_count));

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic bit ref_legal(input logic [31:0] ins);
      logic [6:0] op = ins[6:0];
      logic [2:0] f3 = ins[14:12];
      logic [6:0] f7 = ins[31:25];
      if (op == 7'h33) return f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      if (op == 7'h13) begin
         if (f3 == 3'd1) return f7 == 7'h00;
         if (f3 == 3'd5) return f7 == 7'h00 || f7 == 7'h20;
         return 1;
      end
      return 0;
   endfunction

   function automatic ref_uop_t ref_decode(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
      ref_uop_t u;
      bit r = ins[6:0] == 7'h33;
      bit sh = !r && (ins[14:12] == 3'd1 || ins[14:12] == 3'd5);
      logic [11:0] i12 = ins[31:20];
      u.a   = a;
      u.op  = ins[6:0];
      u.f3  = ins[14:12];
      u.rd  = ins[11:7];
      u.f7  = (r || sh) ? ins[31:25] : 7'd0;
      u.imm = r ? 32'd0 : sh ? 32'(ins[24:20]) : 32'($signed(i12));
      u.b   = r ? b : u.imm;
      return u;
   endfunction

   task automatic verify();
      check("out_valid", out_valid, q.size() > 0);
      check("in_ready", in_ready, q.size() < 2);
      check("illegal_pulse", illegal_pulse, m_pulse);
      check("illegal_count", illegal_count, (m_count > 255) ? 255 : m_count);
      check("illegal_count_w2", d2_count, (m_count > 3) ? 3 : m_count);
      if (q.size() > 0)
         check("payload", {out_A, out_B, out_opcode, out_func3, out_func7, out_imm, out_rd}, q[0]);
   endtask

   task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                       input bit ordy, input bit fl);
      bit acc, pop;
      in_valid = v; in_instr = ins; in_rs1_data = a; in_rs2_data = b; out_ready = ordy; flush = fl;
      acc = v && q.size() < 2;
      pop = q.size() > 0 && ordy;
      @(posedge clk);
      m_pulse = 0;
      if (fl) q.delete();
      else begin
         if (pop) void'(q.pop_front());
         if (acc) begin
            if (ref_legal(ins)) q.push_back(ref_decode(ins, a, b));
            else begin
               m_pulse = 1;
               m_count++;
            end
         end
      end
      @(negedge clk);
      verify();
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] ins = $urandom;
      int sel = $urandom_range(0, 9);
      int f = $urandom_range(0, 2);
      logic [6:0] f7 = (f == 0) ? 7'h00 : (f == 1) ? 7'h20 : 7'($urandom);
      if (sel < 4) begin
         ins[6:0] = 7'h33;
         ins[31:25] = f7;
      end else if (sel < 8) begin
         ins[6:0] = 7'h13;
         if (ins[14:12] == 3'd1 || ins[14:12] == 3'd5) ins[31:25] = f7;
      end
      return ins;
   endfunction

   task automatic do_reset();
      rst_n = 0;
      q.delete();
      m_pulse = 0;
      m_count = 0;
      @(negedge clk);
      @(negedge clk);
      verify();
      rst_n = 1;
   endtask

   initial begin
      in_valid = 0;
      @(negedge clk);
      do_reset();
      check("reset_payload", {out_A, out_B, out_opcode, out_func3, out_func7, out_imm, out_rd}, 128'd0);
      check("reset_in_ready", in_ready, 1'b1);

      step(1, 32'hFFF00293, 32'd7, 32'd99, 1, 0);
      check("addi_valid", out_valid, 1'b1);
      check("addi", {out_A, out_B, out_imm, out_opcode, out_func3, out_func7, out_rd},
            {32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 7'b0010011, 3'b000, 7'd0, 5'd5});
      step(1, 32'h40415513, 32'h80000000, 32'd1, 1, 0);
      check("srai", {out_B, out_imm, out_func3, out_func7, out_rd},
            {32'd4, 32'd4, 3'b101, 7'b0100000, 5'd10});
      step(0, 0, 0, 0, 1, 0);

      step(1, 32'h00208033, 32'd1, 32'd2, 0, 0);
      step(1, 32'h40310133, 32'd3, 32'd4, 0, 0);
      check("bp_in_ready_low", in_ready, 1'b0);
      step(1, 32'h0041F1B3, 32'd5, 32'd6, 0, 0);
      check("bp_head_first", out_A, 32'd1);
      for (int i = 0; i < 5; i++) step(i < 2, 32'h0041F1B3, 32'd5, 32'd6, 1, 0);
      check("bp_drained", out_valid, 1'b0);

      step(1, 32'h00002083, 0, 0, 1, 0);
      check("illegal_load_pulse", illegal_pulse, 1'b1);
      step(1, 32'h4020F033, 0, 0, 1, 0);
      step(0, 0, 0, 0, 1, 0);
      check("illegal_two", illegal_count, 8'd2);
      for (int i = 0; i < 3; i++) step(1, 32'h00002083, 0, 0, 1, 0);
      check("illegal_sat_w2", d2_count, 2'd3);
      check("illegal_five", illegal_count, 8'd5);

      step(1, 32'h00100093, 32'd10, 0, 0, 0);
      step(1, 32'h00200113, 32'd11, 0, 0, 0);
      step(1, 32'h00300193, 32'd12, 0, 0, 1);
      check("flush_valid", out_valid, 1'b0);
      check("flush_ready", in_ready, 1'b1);
      step(1, 32'h00002083, 0, 0, 1, 1);
      check("flush_no_pulse", illegal_pulse, 1'b0);
      step(0, 0, 0, 0, 1, 0);

      for (int i = 0; i < 3000; i++)
         step($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom,
              $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);

      step(1, 32'h00002083, 0, 0, 0, 0);
      step(1, 32'h00100093, 32'd1, 0, 0, 0);
      step(1, 32'h00200093, 32'd2, 0, 0, 0);
      #2 rst_n = 0;
      #1;
      check("async_valid", out_valid, 1'b0);
      check("async_count", illegal_count, 8'd0);
      q.delete();
      m_pulse = 0;
      m_count = 0;
      @(negedge clk);
      verify();
      rst_n = 1;
      step(1, 32'hFFF00293, 32'd7, 0, 1, 0);
      check("post_reset_latency", {out_valid, out_A}, {1'b1, 32'd7});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
